// File: rtl/char_action_decoder_if.sv
// rtl/char_action_decoder_if.sv - frame/state input and character output bundle for char_action_decoder
//
// Signals:
//   FRAME_EN      one-cycle pulse per game frame (master -> slave)
//   STATE         4-bit character state code from the key-input FSM (master -> slave)
//   POS_X         character left-edge X coordinate (slave -> master)
//   HITBOX_ACTIVE attack hitbox live (slave -> master)
//   HITBOX_X0/X1  inclusive hitbox horizontal extent (slave -> master)
//   PHASE_CNT     frames spent in the current state (slave -> master)
//   ATTACK_COUNT  attacks that reached the active phase, mod 256 (slave -> master)
//   SEQ_ERR       sticky protocol-violation flag (slave -> master)
interface char_action_decoder_if;
    logic       FRAME_EN;
    logic [3:0] STATE;
    logic [9:0] POS_X;
    logic       HITBOX_ACTIVE;
    logic [9:0] HITBOX_X0;
    logic [9:0] HITBOX_X1;
    logic [4:0] PHASE_CNT;
    logic [7:0] ATTACK_COUNT;
    logic       SEQ_ERR;

    modport master (
        output FRAME_EN, STATE,
        input  POS_X, HITBOX_ACTIVE, HITBOX_X0, HITBOX_X1, PHASE_CNT, ATTACK_COUNT, SEQ_ERR
    );

    modport slave (
        input  FRAME_EN, STATE,
        output POS_X, HITBOX_ACTIVE, HITBOX_X0, HITBOX_X1, PHASE_CNT, ATTACK_COUNT, SEQ_ERR
    );
endinterface

// File: rtl/char_action_decoder.sv
// rtl/char_action_decoder.sv - per-frame character motion, hitbox, phase counter and protocol checker
//
// Ports:
//   CLOCK    system clock, all state changes on its rising edge
//   RESET_N  asynchronous active-low reset
//   bus      char_action_decoder_if.slave: FRAME_EN/STATE in, registered character outputs out
//
// STATE is sampled only when FRAME_EN is high; every output is a register that
// updates on the following cycle and holds between frames.
module char_action_decoder #(
    parameter logic [9:0] START_X     = 10'd100,
    parameter logic [9:0] MIN_X       = 10'd0,
    parameter logic [9:0] MAX_X       = 10'd576,
    parameter logic [9:0] STEP        = 10'd3,
    parameter logic [9:0] CHAR_W      = 10'd64,
    parameter logic [9:0] RANGE_BASIC = 10'd40,
    parameter logic [9:0] RANGE_DIR   = 10'd56
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    char_action_decoder_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE         = 4'd0,
        S_LEFT         = 4'd1,
        S_RIGHT        = 4'd2,
        S_ATK_START    = 4'd3,
        S_ATK_ACTIVE   = 4'd4,
        S_ATK_RECOVERY = 4'd5,
        S_DIR_START    = 4'd6,
        S_DIR_ACTIVE   = 4'd7,
        S_DIR_RECOVERY = 4'd8
    } code_e;

    localparam logic [11:0] SCREEN_MAX = 12'd639;

    code_e      prev_q,   prev_d;
    logic [9:0] pos_q,    pos_d;
    logic       hb_q,     hb_d;
    logic [9:0] x0_q,     x0_d;
    logic [9:0] x1_q,     x1_d;
    logic [4:0] phase_q,  phase_d;
    logic [7:0] cnt_q,    cnt_d;
    logic       err_q,    err_d;

    logic        in_range;
    code_e       code;
    logic [10:0] pos_ext;
    logic [10:0] right_sum;
    logic [9:0]  hb_range;
    logic [11:0] x0_ext;
    logic [11:0] x1_ext;

    function automatic logic is_legal(input code_e p, input code_e c);
        logic ok;
        ok = 1'b0;
        if (p == c) begin
            ok = 1'b1;
        end else begin
            case (p)
                S_IDLE:         ok = (c == S_LEFT) || (c == S_RIGHT) || (c == S_ATK_START);
                S_LEFT,
                S_RIGHT:        ok = (c == S_IDLE) || (c == S_LEFT) || (c == S_RIGHT) || (c == S_DIR_START);
                S_ATK_START:    ok = (c == S_ATK_ACTIVE);
                S_ATK_ACTIVE:   ok = (c == S_ATK_RECOVERY);
                S_ATK_RECOVERY: ok = (c == S_IDLE);
                S_DIR_START:    ok = (c == S_DIR_ACTIVE);
                S_DIR_ACTIVE:   ok = (c == S_DIR_RECOVERY);
                S_DIR_RECOVERY: ok = (c == S_IDLE);
                default:        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    always_comb begin
        // Codes 9-15 behave as IDLE for everything except the error flag.
        in_range  = (bus.STATE <= 4'd8);
        code      = in_range ? code_e'(bus.STATE) : S_IDLE;

        prev_d    = prev_q;
        pos_d     = pos_q;
        hb_d      = hb_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        pos_ext   = {1'b0, pos_q};
        right_sum = pos_ext + {1'b0, STEP};
        hb_range  = (code == S_DIR_ACTIVE) ? RANGE_DIR : RANGE_BASIC;
        x0_ext    = 12'd0;
        x1_ext    = 12'd0;

        if (bus.FRAME_EN) begin
            prev_d = code;

            // Motion: compare before subtracting so the left wall never wraps.
            if (code == S_LEFT) begin
                if (pos_ext >= ({1'b0, MIN_X} + {1'b0, STEP})) begin
                    pos_d = pos_q - STEP;
                end else begin
                    pos_d = MIN_X;
                end
            end else if (code == S_RIGHT) begin
                if (right_sum > {1'b0, MAX_X}) begin
                    pos_d = MAX_X;
                end else begin
                    pos_d = right_sum[9:0];
                end
            end

            // Hitbox uses the position of this same frame; widened so the
            // screen-edge saturation sees the true sum.
            x0_ext = {2'b00, pos_d} + {2'b00, CHAR_W};
            x1_ext = x0_ext + {2'b00, hb_range} - 12'd1;
            if ((code == S_ATK_ACTIVE) || (code == S_DIR_ACTIVE)) begin
                hb_d = 1'b1;
                x0_d = (x0_ext > SCREEN_MAX) ? SCREEN_MAX[9:0] : x0_ext[9:0];
                x1_d = (x1_ext > SCREEN_MAX) ? SCREEN_MAX[9:0] : x1_ext[9:0];
            end else begin
                hb_d = 1'b0;
                x0_d = 10'd0;
                x1_d = 10'd0;
            end

            if (code != prev_q) begin
                phase_d = 5'd0;
            end else if (phase_q != 5'd31) begin
                phase_d = phase_q + 5'd1;
            end

            if (((prev_q == S_ATK_START) && (code == S_ATK_ACTIVE)) ||
                ((prev_q == S_DIR_START) && (code == S_DIR_ACTIVE))) begin
                cnt_d = cnt_q + 8'd1;
            end

            if (!in_range || !is_legal(prev_q, code)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            prev_q  <= S_IDLE;
            pos_q   <= START_X;
            hb_q    <= 1'b0;
            x0_q    <= 10'd0;
            x1_q    <= 10'd0;
            phase_q <= 5'd0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            hb_q    <= hb_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.POS_X         = pos_q;
    assign bus.HITBOX_ACTIVE = hb_q;
    assign bus.HITBOX_X0     = x0_q;
    assign bus.HITBOX_X1     = x1_q;
    assign bus.PHASE_CNT     = phase_q;
    assign bus.ATTACK_COUNT  = cnt_q;
    assign bus.SEQ_ERR       = err_q;

endmodule

// File: tb/tb_char_action_decoder.sv
// tb/tb_char_action_decoder.sv - self-checking bench for char_action_decoder
module tb_char_action_decoder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hb_frames;

    char_action_decoder_if bus();

    char_action_decoder u_dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers and a successor table.
    int      m_pos, m_prev, m_phase, m_cnt, m_err, m_hb, m_x0, m_x1;
    bit [8:0] succ [9];

    function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
    function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction

    task automatic build_table();
        for (int i = 0; i < 9; i++) succ[i] = '0;
        succ[0][1] = 1; succ[0][2] = 1; succ[0][3] = 1;
        for (int p = 1; p <= 2; p++) begin
            succ[p][0] = 1; succ[p][1] = 1; succ[p][2] = 1; succ[p][6] = 1;
        end
        succ[3][4] = 1; succ[4][5] = 1; succ[5][0] = 1;
        succ[6][7] = 1; succ[7][8] = 1; succ[8][0] = 1;
    endtask

    task automatic model_reset();
        m_pos = 100; m_prev = 0; m_phase = 0; m_cnt = 0;
        m_err = 0; m_hb = 0; m_x0 = 0; m_x1 = 0;
    endtask

    task automatic model_step(input int raw);
        int c;
        c = (raw > 8) ? 0 : raw;
        if (raw > 8 || !(c == m_prev || succ[m_prev][c])) m_err = 1;
        m_phase = (c == m_prev) ? imin(m_phase + 1, 31) : 0;
        if ((m_prev == 3 && c == 4) || (m_prev == 6 && c == 7)) m_cnt = (m_cnt + 1) % 256;
        if (c == 1) m_pos = imax(m_pos - 3, 0);
        if (c == 2) m_pos = imin(m_pos + 3, 576);
        if (c == 4 || c == 7) begin
            m_hb = 1;
            m_x0 = imin(m_pos + 64, 639);
            m_x1 = imin(m_pos + 64 + ((c == 4) ? 40 : 56) - 1, 639);
        end else begin
            m_hb = 0; m_x0 = 0; m_x1 = 0;
        end
        m_prev = c;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string where);
        check({where, "_pos"},   32'(bus.POS_X),         32'(m_pos));
        check({where, "_hb"},    32'(bus.HITBOX_ACTIVE), 32'(m_hb));
        check({where, "_x0"},    32'(bus.HITBOX_X0),     32'(m_x0));
        check({where, "_x1"},    32'(bus.HITBOX_X1),     32'(m_x1));
        check({where, "_phase"}, 32'(bus.PHASE_CNT),     32'(m_phase));
        check({where, "_cnt"},   32'(bus.ATTACK_COUNT),  32'(m_cnt));
        check({where, "_err"},   32'(bus.SEQ_ERR),       32'(m_err));
    endtask

    // One frame: pulse FRAME_EN with the code, then scramble STATE so a
    // late change cannot leak into the result.
    task automatic frame(input int code);
        @(negedge clk);
        bus.STATE    = 4'(code);
        bus.FRAME_EN = 1'b1;
        @(negedge clk);
        bus.FRAME_EN = 1'b0;
        bus.STATE    = 4'($urandom);
        model_step(code);
        if (bus.HITBOX_ACTIVE === 1'b1) hb_frames++;
        compare_all("frame");
    endtask

    task automatic frames(input int code, input int n);
        for (int i = 0; i < n; i++) frame(code);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        compare_all("rst_hold");
    endtask

    task automatic release_plain();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic release_with_frame(input int code);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.STATE    = 4'(code);
        bus.FRAME_EN = 1'b1;
        @(negedge clk);
        bus.FRAME_EN = 1'b0;
        model_step(code);
        compare_all("rel_frame");
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.STATE = 4'($urandom);
            compare_all("gap_hold");
        end
    endtask

    function automatic int pick_code();
        int cand [$];
        if ($urandom_range(0, 9) < 8) begin
            cand.push_back(m_prev);
            for (int c = 0; c < 9; c++) if (succ[m_prev][c]) cand.push_back(c);
            return cand[$urandom_range(0, cand.size() - 1)];
        end
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        hb_frames    = 0;
        rst_n        = 1'b0;
        bus.FRAME_EN = 1'b0;
        bus.STATE    = 4'd0;
        build_table();
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_pos",   32'(bus.POS_X), 32'd100);
        check("reset_hb",    32'(bus.HITBOX_ACTIVE), 32'd0);
        check("reset_x0",    32'(bus.HITBOX_X0), 32'd0);
        check("reset_cnt",   32'(bus.ATTACK_COUNT), 32'd0);
        check("reset_err",   32'(bus.SEQ_ERR), 32'd0);
        release_plain();
        gap(3);

        // Walk test
        frames(2, 10);
        check("walk_pos",   32'(bus.POS_X), 32'd130);
        check("walk_phase", 32'(bus.PHASE_CNT), 32'd9);
        check("walk_err",   32'(bus.SEQ_ERR), 32'd0);
        gap(2);
        check("walk_hold",  32'(bus.POS_X), 32'd130);
        frames(1, 10);
        frame(0);

        // Basic attack at POS_X=100
        hb_frames = 0;
        frame(0);
        frames(3, 5);
        frame(4);
        check("atk_x0", 32'(bus.HITBOX_X0), 32'd164);
        check("atk_x1", 32'(bus.HITBOX_X1), 32'd203);
        frame(4);
        frames(5, 16);
        check("atk_rec_phase", 32'(bus.PHASE_CNT), 32'd15);
        frame(0);
        check("atk_hb_frames", 32'(hb_frames), 32'd2);
        check("atk_count",     32'(bus.ATTACK_COUNT), 32'd1);
        check("atk_err",       32'(bus.SEQ_ERR), 32'd0);

        // Right wall and phase saturation, then directional attack at 576
        frames(2, 159);
        check("rwall_pos",   32'(bus.POS_X), 32'd576);
        check("phase_sat",   32'(bus.PHASE_CNT), 32'd31);
        hb_frames = 0;
        frames(6, 4);
        frames(7, 3);
        check("dir_x0", 32'(bus.HITBOX_X0), 32'd639);
        check("dir_x1", 32'(bus.HITBOX_X1), 32'd639);
        frame(8);
        frame(0);
        check("dir_hb_frames", 32'(hb_frames), 32'd3);
        check("dir_count",     32'(bus.ATTACK_COUNT), 32'd2);

        // Reset mid-attack; FRAME_EN in the release cycle is sampled vs PREV=IDLE
        frame(0);
        frame(3);
        frame(4);
        do_reset();
        check("midatk_cnt", 32'(bus.ATTACK_COUNT), 32'd0);
        release_with_frame(3);
        check("rel_err",   32'(bus.SEQ_ERR), 32'd0);
        check("rel_phase", 32'(bus.PHASE_CNT), 32'd0);
        frame(4);
        frame(5);
        frame(0);

        // Left wall: 100 -> 1 -> 0 -> 0
        frames(1, 33);
        check("lwall_pre", 32'(bus.POS_X), 32'd1);
        frame(1);
        check("lwall_0", 32'(bus.POS_X), 32'd0);
        frame(1);
        check("lwall_stay", 32'(bus.POS_X), 32'd0);
        frame(0);

        // Protocol error: IDLE -> ATK_ACTIVE
        frame(4);
        check("perr_err", 32'(bus.SEQ_ERR), 32'd1);
        check("perr_hb",  32'(bus.HITBOX_ACTIVE), 32'd1);
        frame(5);
        frame(0);
        frames(2, 3);
        check("perr_sticky", 32'(bus.SEQ_ERR), 32'd1);
        frame(0);
        frame(12);
        check("code12_pos", 32'(bus.POS_X), 32'd9);
        check("code12_err", 32'(bus.SEQ_ERR), 32'd1);
        check("code12_hb",  32'(bus.HITBOX_ACTIVE), 32'd0);
        frame(1);
        check("code12_left", 32'(bus.POS_X), 32'd6);
        do_reset();
        check("perr_cleared", 32'(bus.SEQ_ERR), 32'd0);
        release_plain();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
                if ($urandom_range(0, 1) == 1) release_with_frame(pick_code());
                else release_plain();
            end else begin
                frame(pick_code());
                gap(int'($urandom_range(0, 2)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/char_action_decoder.md
CHAR_ACTION_DECODER -- requirements
Module: char_action_decoder

Interface
REQ-001 SHALL have parameter START_X, default 10'd100, reset X position of the character's left edge in pixels.
REQ-002 SHALL have parameter MIN_X, default 10'd0, lowest legal POS_X.
REQ-003 SHALL have parameter MAX_X, default 10'd576, highest legal POS_X.
REQ-004 SHALL have parameter STEP, default 10'd3, pixels moved per frame in LEFT or RIGHT.
REQ-005 SHALL have parameter CHAR_W, default 10'd64, character body width in pixels.
REQ-006 SHALL have parameters RANGE_BASIC (default 10'd40) and RANGE_DIR (default 10'd56), hitbox reach beyond the body for basic and directional attacks.
REQ-007 SHALL have port CLOCK, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-008 SHALL have port RESET_N, input, 1, reset; asynchronous and active-low.
REQ-009 SHALL have port FRAME_EN, input, 1, a one-cycle pulse once per game frame.
REQ-010 SHALL have port STATE, input, 4, the character state code from the key-input FSM: 0 IDLE, 1 LEFT, 2 RIGHT, 3 ATK_START, 4 ATK_ACTIVE, 5 ATK_RECOVERY, 6 DIR_START, 7 DIR_ACTIVE, 8 DIR_RECOVERY.
REQ-011 SHALL have port POS_X, output, 10, the character's left-edge X coordinate.
REQ-012 SHALL have port HITBOX_ACTIVE, output, 1, high while an attack hitbox is live.
REQ-013 SHALL have ports HITBOX_X0 and HITBOX_X1, output, 10 each, the inclusive hitbox horizontal extent.
REQ-014 SHALL have port PHASE_CNT, output, 5, the number of frames spent in the current state.
REQ-015 SHALL have port ATTACK_COUNT, output, 8, the number of attacks that reached the active phase.
REQ-016 SHALL have port SEQ_ERR, output, 1, a sticky protocol-violation flag.

Function
REQ-017 SHALL sample STATE only in cycles where FRAME_EN=1; all outputs SHALL be registered and update on the cycle after that sample (latency 1), and SHALL hold otherwise.
REQ-018 SHALL hold the previously sampled state, PREV (reset value IDLE).
REQ-019 On a sampled LEFT, SHALL set POS_X to max(POS_X-STEP, MIN_X), computed without unsigned underflow (compare before subtracting).
REQ-020 On a sampled RIGHT, SHALL set POS_X to min(POS_X+STEP, MAX_X), computed at 11 bits and then clamped.
REQ-021 For all other sampled codes, SHALL leave POS_X unchanged.
REQ-022 SHALL drive HITBOX_ACTIVE=1 exactly for frames whose sampled code is ATK_ACTIVE or DIR_ACTIVE, and 0 otherwise.
REQ-023 While the hitbox is active, SHALL set HITBOX_X0=POS_X+CHAR_W and HITBOX_X1=POS_X+CHAR_W+RANGE-1, where RANGE is RANGE_BASIC or RANGE_DIR, using the POS_X in effect for the same frame; both values SHALL be saturated at 639.
REQ-024 While the hitbox is inactive, SHALL hold HITBOX_X0=HITBOX_X1=0.
REQ-025 On each sample, SHALL reset PHASE_CNT to 0 if the code differs from PREV, and otherwise increment it, saturating at 31.
REQ-026 SHALL increment ATTACK_COUNT, wrapping modulo 256, on every sample with PREV=ATK_START and code=ATK_ACTIVE, or PREV=DIR_START and code=DIR_ACTIVE.
REQ-027 SHALL treat these as the only legal transitions (PREV -> code); a self-transition is always legal:
  IDLE -> LEFT, RIGHT or ATK_START
  LEFT/RIGHT -> IDLE, LEFT, RIGHT or DIR_START
  ATK_START -> ATK_ACTIVE; ATK_ACTIVE -> ATK_RECOVERY; ATK_RECOVERY -> IDLE
  DIR_START -> DIR_ACTIVE; DIR_ACTIVE -> DIR_RECOVERY; DIR_RECOVERY -> IDLE
REQ-028 On any illegal transition, or any code of 9-15, SHALL set SEQ_ERR=1 and keep it set until reset.
REQ-029 SHALL decode a code of 9-15 as IDLE: no motion, no hitbox, and PREV<=IDLE.
REQ-030 On an illegal but in-range transition, SHALL still apply the new code's motion and hitbox rules, and PREV SHALL take the new code.
REQ-031 SHALL ignore STATE changes between FRAME_EN pulses; only the value present at the pulse is used.

Reset
REQ-032 While RESET_N=0, SHALL force asynchronously: POS_X=START_X, PREV=IDLE, HITBOX_ACTIVE=0, HITBOX_X0=HITBOX_X1=0, PHASE_CNT=0, ATTACK_COUNT=0, SEQ_ERR=0.
REQ-033 A reset asserted mid-attack SHALL abort it; the first sample after release SHALL be checked against PREV=IDLE.
REQ-034 A FRAME_EN in the cycle RESET_N releases SHALL be sampled normally.

Verification
REQ-035 Walk test: from reset, 10 frames of RIGHT -> POS_X=130, PHASE_CNT=9, SEQ_ERR=0.
REQ-036 Left wall: POS_X=2, one LEFT frame -> POS_X=0 (no wrap); a further LEFT frame -> POS_X stays 0.
REQ-037 Basic attack: IDLE, then ATK_START x5, ATK_ACTIVE x2, ATK_RECOVERY x16, IDLE at POS_X=100 -> HITBOX_ACTIVE=1 for exactly 2 frames with X0=164 and X1=203; ATTACK_COUNT=1.
REQ-038 Directional attack at POS_X=576: RIGHT, DIR_START x4, DIR_ACTIVE x3 -> X0=639 and X1=639 (saturated); hitbox active for 3 frames.
REQ-039 Protocol error: IDLE -> ATK_ACTIVE -> SEQ_ERR=1 with hitbox active that frame; SEQ_ERR stays 1 through later legal traffic and clears only on RESET_N=0.
REQ-040 Code 12 sampled -> SEQ_ERR=1, no movement; then the following LEFT is accepted (legal from IDLE) and POS_X decreases by 3.
